cond_flag_unit: RTL and testbench

- Producer side of the branch-condition interface: owns the architectural zero/sign/carry flags consumed by the jump controller.
- Latches flags from ALU results, handles set/clear-carry, and issues a one-cycle jmpWake with its op.
- Clears the tested flag when the jump controller reports a taken jump.
- Holds a small flag save/restore stack for interrupt entry and return.

---
 rtl/cond_flag_unit.sv | 149 ++++++++++++++
 tb/tb_cond_flag_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// Branch-condition flag producer: Z/N/C flags, branch wake strobe, jump-consume clears and a
// flag save/restore stack. Define FLAG_OVF_EN to add the V (overflow) flag.
module cond_flag_unit #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] aluRes,
  input  logic              aluCout,
`ifdef FLAG_OVF_EN
  input  logic              aluOvf,
  input  logic [3:0]        updMask,
`else
  input  logic [2:0]        updMask,
`endif
  input  logic              aluValid,
  input  logic              setc,
  input  logic              clrc,
  input  logic              brValid,
  input  logic [3:0]        brOp,
  input  logic              jmpTaken,
  input  logic              push,
  input  logic              pop,
  output logic              zero,
  output logic              sign,
  output logic              carry,
`ifdef FLAG_OVF_EN
  output logic              ovf,
`endif
  output logic              jmpWake,
  output logic [3:0]        jmpOp,
  output logic              stkFull,
  output logic              stkEmpty,
  output logic              stkErr
);

`ifdef FLAG_OVF_EN
  localparam int unsigned EntW = 4;
`else
  localparam int unsigned EntW = 3;
`endif
  localparam int unsigned AddrW = $clog2(STACK_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [PtrW-1:0] PtrFull = PtrW'(STACK_DEPTH);

  // Flag vector layout: bit 0 Z, bit 1 N, bit 2 C, bit 3 V (when enabled).
  logic [EntW-1:0] flg_q, flg_d;
  logic [EntW-1:0] alu_flg;
  logic [EntW-1:0] stk_q [STACK_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            wake_q;
  logic [3:0]      op_q;
  logic            full_q, empty_q, err_q, err_d;
  logic            push_only, pop_only, push_ok, pop_ok;
  logic [AddrW-1:0] push_idx, pop_idx;

`ifdef FLAG_OVF_EN
  assign alu_flg = {aluOvf, aluCout, aluRes[DATA_W-1], aluRes == '0};
`else
  assign alu_flg = {aluCout, aluRes[DATA_W-1], aluRes == '0};
`endif

  assign push_only = push && !pop;
  assign pop_only  = pop && !push;
  assign push_ok   = push_only && (ptr_q != PtrFull);
  assign pop_ok    = pop_only && (ptr_q != '0);
  assign push_idx  = ptr_q[AddrW-1:0];
  assign pop_idx   = AddrW'(ptr_q - 1'b1);

  // Sources are applied lowest priority first so later assignments win.
  always_comb begin
    flg_d = flg_q;
    if (wake_q && jmpTaken) begin
      case (op_q)
        4'd0, 4'd1, 4'd2, 4'd3: flg_d[0] = 1'b0;
        4'd4, 4'd5, 4'd6, 4'd7: flg_d[1] = 1'b0;
        4'd8, 4'd9:             flg_d[2] = 1'b0;
`ifdef FLAG_OVF_EN
        4'd11, 4'd12:           flg_d[3] = 1'b0;
`endif
        default: ;
      endcase
    end
    if (setc && !clrc) begin
      flg_d[2] = 1'b1;
    end else if (clrc && !setc) begin
      flg_d[2] = 1'b0;
    end
    if (aluValid) begin
      for (int i = 0; i < int'(EntW); i++) begin
        if (updMask[i]) flg_d[i] = alu_flg[i];
      end
    end
    if (pop_ok) begin
      flg_d = stk_q[pop_idx];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    err_d = err_q;
    if (push_ok) begin
      ptr_d = ptr_q + 1'b1;
    end else if (pop_ok) begin
      ptr_d = ptr_q - 1'b1;
    end
    if ((push_only && !push_ok) || (pop_only && !pop_ok)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flg_q   <= '0;
      wake_q  <= 1'b0;
      op_q    <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      flg_q   <= flg_d;
      wake_q  <= brValid;
      if (brValid) op_q <= brOp;
      ptr_q   <= ptr_d;
      full_q  <= (ptr_d == PtrFull);
      empty_q <= (ptr_d == '0);
      err_q   <= err_d;
      if (push_ok) stk_q[push_idx] <= flg_q;
    end
  end

  assign zero     = flg_q[0];
  assign sign     = flg_q[1];
  assign carry    = flg_q[2];
`ifdef FLAG_OVF_EN
  assign ovf      = flg_q[3];
`endif
  assign jmpWake  = wake_q;
  assign jmpOp    = op_q;
  assign stkFull  = full_q;
  assign stkEmpty = empty_q;
  assign stkErr   = err_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: queue-based flag model compared every cycle plus
// directed literal checks.
module tb_cond_flag_unit;
  localparam int unsigned DataW = 16;
  localparam int unsigned Depth = 4;
`ifdef FLAG_OVF_EN
  localparam int unsigned MaskW = 4;
`else
  localparam int unsigned MaskW = 3;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [DataW-1:0] aluRes;
  logic             aluCout, aluValid, setc, clrc, brValid, jmpTaken, push, pop;
  logic [MaskW-1:0] updMask;
  logic [3:0]       brOp;
  logic             zero, sign, carry, jmpWake, stkFull, stkEmpty, stkErr;
  logic [3:0]       jmpOp;
`ifdef FLAG_OVF_EN
  logic             aluOvf = 1'b0;
  logic             ovf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  cond_flag_unit #(.DATA_W(DataW), .STACK_DEPTH(Depth)) dut (
    .clk      (clk),
    .rst      (rst),
    .aluRes   (aluRes),
    .aluCout  (aluCout),
`ifdef FLAG_OVF_EN
    .aluOvf   (aluOvf),
    .ovf      (ovf),
`endif
    .updMask  (updMask),
    .aluValid (aluValid),
    .setc     (setc),
    .clrc     (clrc),
    .brValid  (brValid),
    .brOp     (brOp),
    .jmpTaken (jmpTaken),
    .push     (push),
    .pop      (pop),
    .zero     (zero),
    .sign     (sign),
    .carry    (carry),
    .jmpWake  (jmpWake),
    .jmpOp    (jmpOp),
    .stkFull  (stkFull),
    .stkEmpty (stkEmpty),
    .stkErr   (stkErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: plain flag bits and a queue as the save stack.
  bit       m_z, m_n, m_c, m_wake, m_err;
  bit [3:0] m_op;
  bit [2:0] m_stk[$];

  always @(posedge clk or negedge rst) begin
    bit nz, nn, nc;
    bit [2:0] ent;
    if (!rst) begin
      m_z = 0; m_n = 0; m_c = 0; m_wake = 0; m_err = 0; m_op = 0;
      m_stk.delete();
    end else begin
      nz = m_z; nn = m_n; nc = m_c;
      if (m_wake && jmpTaken) begin
        if (m_op <= 3) nz = 0;
        else if (m_op <= 7) nn = 0;
        else if (m_op <= 9) nc = 0;
      end
      if (setc && !clrc) nc = 1;
      if (clrc && !setc) nc = 0;
      if (aluValid) begin
        if (updMask[0]) nz = (aluRes == 0);
        if (updMask[1]) nn = aluRes[DataW-1];
        if (updMask[2]) nc = aluCout;
      end
      if (push && !pop) begin
        if (m_stk.size() == int'(Depth)) m_err = 1;
        else m_stk.push_back({m_c, m_n, m_z});
      end else if (pop && !push) begin
        if (m_stk.size() == 0) m_err = 1;
        else begin
          ent = m_stk.pop_back();
          {nc, nn, nz} = ent;
        end
      end
      m_z = nz; m_n = nn; m_c = nc;
      m_wake = brValid;
      if (brValid) m_op = brOp;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("zero", int'(zero), int'(m_z));
      chk("sign", int'(sign), int'(m_n));
      chk("carry", int'(carry), int'(m_c));
      chk("jmpWake", int'(jmpWake), int'(m_wake));
      if (m_wake) chk("jmpOp", int'(jmpOp), int'(m_op));
      chk("stkFull", int'(stkFull), int'(m_stk.size() == int'(Depth)));
      chk("stkEmpty", int'(stkEmpty), int'(m_stk.size() == 0));
      chk("stkErr", int'(stkErr), int'(m_err));
    end
  end

  task automatic clr_in();
    aluRes = '0; aluCout = 0; aluValid = 0; updMask = '0; setc = 0; clrc = 0;
    brValid = 0; brOp = '0; jmpTaken = 0; push = 0; pop = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    clr_in();
  endtask

  task automatic alu(input logic [DataW-1:0] res, input logic co, input logic [2:0] m);
    aluValid = 1; aluRes = res; aluCout = co; updMask = MaskW'(m);
  endtask

  initial begin
    clr_in();
    repeat (3) @(posedge clk);
    #2 rst = 1;
    chk("rst_zero", int'(zero), 0);
    chk("rst_carry", int'(carry), 0);
    chk("rst_wake", int'(jmpWake), 0);
    chk("rst_empty", int'(stkEmpty), 1);
    chk("rst_full", int'(stkFull), 0);
    chk("rst_err", int'(stkErr), 0);

    alu(16'h0000, 1, 3'b111); tick();
    chk("alu_all_z", int'(zero), 1);
    chk("alu_all_n", int'(sign), 0);
    chk("alu_all_c", int'(carry), 1);

    alu(16'h8000, 0, 3'b001); tick();
    chk("mask_z", int'(zero), 0);
    chk("mask_n_hold", int'(sign), 0);
    chk("mask_c_hold", int'(carry), 1);

    alu(16'h0000, 0, 3'b001); tick();
    brValid = 1; brOp = 4'd0; tick();
    chk("wake_op0", int'(jmpWake), 1);
    chk("op0", int'(jmpOp), 0);
    jmpTaken = 1; tick();
    chk("taken_clr_z", int'(zero), 0);
    chk("wake_one_cycle", int'(jmpWake), 0);

    brValid = 1; brOp = 4'd0; tick();
    jmpTaken = 1; alu(16'h0000, 0, 3'b001); tick();
    chk("alu_beats_clr", int'(zero), 1);

    alu(16'h8000, 0, 3'b010); brValid = 1; brOp = 4'd4; tick();
    chk("wake_op4", int'(jmpOp), 4);
    chk("n_set", int'(sign), 1);
    jmpTaken = 1; brValid = 1; brOp = 4'd8; tick();
    chk("clr_n", int'(sign), 0);
    chk("wake_op8", int'(jmpOp), 8);
    chk("b2b_wake", int'(jmpWake), 1);
    jmpTaken = 1; brValid = 1; brOp = 4'd10; tick();
    chk("clr_c", int'(carry), 0);
    jmpTaken = 1; tick();
    chk("op10_keeps_z", int'(zero), 1);
    chk("wake_drop", int'(jmpWake), 0);

    alu(16'h0000, 1, 3'b111); tick();
    push = 1; tick();
    chk("push_nonempty", int'(stkEmpty), 0);
    alu(16'h8000, 0, 3'b111); tick();
    chk("mod_n", int'(sign), 1);
    pop = 1; tick();
    chk("pop_z", int'(zero), 1);
    chk("pop_n", int'(sign), 0);
    chk("pop_c", int'(carry), 1);
    chk("pop_empty", int'(stkEmpty), 1);

    for (int i = 0; i < 4; i++) begin
      push = 1; tick();
    end
    chk("full4", int'(stkFull), 1);
    chk("no_err_yet", int'(stkErr), 0);
    push = 1; tick();
    chk("ovf_err", int'(stkErr), 1);
    push = 1; pop = 1; tick();
    chk("pushpop_full", int'(stkFull), 1);
    alu(16'h0001, 0, 3'b111); tick();
    pop = 1; tick();
    chk("top_z", int'(zero), 1);
    chk("top_c", int'(carry), 1);
    chk("pop_notfull", int'(stkFull), 0);

    setc = 1; clrc = 1; tick();
    chk("setclr_hold", int'(carry), 1);
    clrc = 1; tick();
    chk("clrc", int'(carry), 0);
    setc = 1; tick();
    chk("setc", int'(carry), 1);
    setc = 1; alu(16'h0001, 0, 3'b100); tick();
    chk("alu_beats_setc", int'(carry), 0);
    setc = 1; tick();

    brValid = 1; brOp = 4'd2; tick();
    chk("pre_rst_wake", int'(jmpWake), 1);
    #1 rst = 0;
    #1;
    chk("async_wake", int'(jmpWake), 0);
    chk("async_c", int'(carry), 0);
    chk("async_empty", int'(stkEmpty), 1);
    chk("async_err", int'(stkErr), 0);
    @(posedge clk);
    #2 rst = 1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
